cbg_lsu_responder: RTL

// - Memory-side responder for the PE-array LSU request interface: serves per-row read/write requests and returns grant/read data.
// - Inputs: R_request_r, W_request_r, LSU_addr_bus_r. Output: CBG_to_LSU_bus_r (r = 0..3, one bank group per PE row).
// - Each row owns one single-port SRAM bank; its LSU lanes are arbitrated round-robin.
// - A host load port (DMA/preload) shares the banks and has priority.

---
 rtl/cbg_pkg.sv | 48 ++++
 rtl/cbg_rr_arbiter.sv | 43 ++++
 rtl/cbg_lsu_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cbg_pkg.sv
// Shared parameters and helpers for the CBG LSU responder.
// Lane slicing, one-hot and response bus packing.
package cbg_pkg;

  localparam int NLSU   = 4;
  localparam int NROW   = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(NLSU);
  localparam int LANE_W = ADDR_W + DATA_W;
  localparam int A_W    = NLSU * LANE_W;
  localparam int C_W    = 2 * NLSU + DATA_W;

  // Bank word index of lane k; upper address bits alias away.
  function automatic logic [AW-1:0] lane_word(
    input logic [A_W-1:0] bus,
    input logic [LW-1:0]  k
  );
    return bus[int'(k)*LANE_W +: AW];
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(
    input logic [A_W-1:0] bus,
    input logic [LW-1:0]  k
  );
    return bus[int'(k)*LANE_W+ADDR_W +: DATA_W];
  endfunction

  function automatic logic [NLSU-1:0] lane_onehot(
    input logic [LW-1:0] k
  );
    logic [NLSU-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [C_W-1:0] pack_cbg(
    input logic [NLSU-1:0]   rvalid,
    input logic [NLSU-1:0]   gnt,
    input logic [DATA_W-1:0] rdata
  );
    return {rvalid, gnt, rdata};
  endfunction

endpackage

// File: rtl/cbg_rr_arbiter.sv
// Round-robin arbiter over the LSU lanes of one row.
// Combinational one-hot grant, registered rotating pointer.
module cbg_rr_arbiter
  import cbg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            block,
  input  logic [NLSU-1:0] req,
  output logic [NLSU-1:0] gnt,
  output logic [LW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [LW-1:0] ptr;
  logic [LW-1:0] cand;

  // First requester at or after ptr; scanned high-to-low so offset 0 wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = NLSU - 1; i >= 0; i--) begin
      cand = LW'((int'(ptr) + i) % NLSU);
      if (req[cand] && !block) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= LW'((int'(gnt_idx) + 1) % NLSU);
    end
  end

endmodule

// File: rtl/cbg_lsu_responder.sv
// Memory-side responder for the PE-array LSU rows.
// One single-port bank per row, round-robin lanes, host write priority.
module cbg_lsu_responder
  import cbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NLSU-1:0]   R_request_0,
  input  logic [NLSU-1:0]   R_request_1,
  input  logic [NLSU-1:0]   R_request_2,
  input  logic [NLSU-1:0]   R_request_3,
  input  logic [NLSU-1:0]   W_request_0,
  input  logic [NLSU-1:0]   W_request_1,
  input  logic [NLSU-1:0]   W_request_2,
  input  logic [NLSU-1:0]   W_request_3,
  input  logic [A_W-1:0]    LSU_addr_bus_0,
  input  logic [A_W-1:0]    LSU_addr_bus_1,
  input  logic [A_W-1:0]    LSU_addr_bus_2,
  input  logic [A_W-1:0]    LSU_addr_bus_3,
  input  logic              host_we,
  input  logic [1:0]        host_row,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [C_W-1:0]    CBG_to_LSU_bus_0,
  output logic [C_W-1:0]    CBG_to_LSU_bus_1,
  output logic [C_W-1:0]    CBG_to_LSU_bus_2,
  output logic [C_W-1:0]    CBG_to_LSU_bus_3
);

  logic [NLSU-1:0] rq [NROW];
  logic [NLSU-1:0] wq [NROW];
  logic [A_W-1:0]  ab [NROW];
  logic [C_W-1:0]  cb [NROW];

  assign rq[0] = R_request_0;
  assign rq[1] = R_request_1;
  assign rq[2] = R_request_2;
  assign rq[3] = R_request_3;
  assign wq[0] = W_request_0;
  assign wq[1] = W_request_1;
  assign wq[2] = W_request_2;
  assign wq[3] = W_request_3;
  assign ab[0] = LSU_addr_bus_0;
  assign ab[1] = LSU_addr_bus_1;
  assign ab[2] = LSU_addr_bus_2;
  assign ab[3] = LSU_addr_bus_3;

  assign CBG_to_LSU_bus_0 = cb[0];
  assign CBG_to_LSU_bus_1 = cb[1];
  assign CBG_to_LSU_bus_2 = cb[2];
  assign CBG_to_LSU_bus_3 = cb[3];

  for (genvar r = 0; r < NROW; r++) begin : g_row

    logic [NLSU-1:0]   req;
    logic [NLSU-1:0]   gnt;
    logic [LW-1:0]     gidx;
    logic              gany;
    logic              hsel;
    logic              blk;
    logic              is_wr;
    logic              is_rd;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdat;

    logic [DATA_W-1:0] bank [DEPTH];
    logic [DATA_W-1:0] rd_q;

    logic              v1;
    logic [LW-1:0]     lane1;
    logic [NLSU-1:0]   rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign req  = rq[r] | wq[r];
    assign hsel = host_we && (host_row == 2'(r));
    assign blk  = rst || !run || hsel;

    cbg_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .block   (blk),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gidx),
      .gnt_any (gany)
    );

    // A write wins over a read on the same lane; the read is dropped.
    assign is_wr = gany && wq[r][gidx];
    assign is_rd = gany && !wq[r][gidx];
    assign waddr = lane_word(ab[r], gidx);
    assign wdat  = lane_wdata(ab[r], gidx);

    // Single-port bank: host or lane write, registered read.
    always_ff @(posedge clk) begin
      if (hsel) begin
        bank[host_addr] <= host_wdata;
      end else if (is_wr) begin
        bank[waddr] <= wdat;
      end
      if (is_rd) begin
        rd_q <= bank[waddr];
      end
    end

    // Lane tag pipe and output register; rdata holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        v1       <= 1'b0;
        lane1    <= '0;
        rvalid_q <= '0;
        rdata_q  <= '0;
      end else begin
        v1       <= is_rd;
        lane1    <= gidx;
        rvalid_q <= v1 ? lane_onehot(lane1) : '0;
        if (v1) rdata_q <= rd_q;
      end
    end

    assign cb[r] = pack_cbg(rvalid_q, gnt, rdata_q);

  end

endmodule
